// File: rtl/multichannel_fifobram_pkg.sv
// Shared types and helpers for the multi-channel FIFO that sits on one BRAM.
// Optional error flags are enabled with MULTICHANNEL_FIFOBRAM_ERRCHECK_EN (see top).
package multichannel_fifobram_pkg;

   localparam int DEFAULT_ALMOSTFULL_MARGIN = 4;
   localparam int STATUS_COUNT_W            = 16;

   // count is held wider than any practical depth; the top exports the low LOG2_DEPTH+1 bits
   typedef struct packed {
      logic                      empty;
      logic                      almostfull;
      logic [STATUS_COUNT_W-1:0] count;
   } multififo_status_t;

   function automatic int count_lsb(input int channel, input int log2_depth);
      return channel * (log2_depth + 1);
   endfunction

endpackage

// File: rtl/multichannel_fifobram_if.sv
// Write/read/status bundle of the multi-channel BRAM FIFO.
// Sticky error outputs exist only when MULTICHANNEL_FIFOBRAM_ERRCHECK_EN is defined.
interface multichannel_fifobram_if #(
   parameter int WIDTH         = 32,
   parameter int LOG2_DEPTH    = 5,
   parameter int LOG2_CHANNELS = 2
);
   localparam int NUM_CHANNELS = 1 << LOG2_CHANNELS;

   logic                                  we;
   logic [LOG2_CHANNELS-1:0]              wchannel;
   logic [WIDTH-1:0]                      wdata;
   logic                                  re;
   logic [LOG2_CHANNELS-1:0]              rchannel;
   logic [WIDTH-1:0]                      rdata;
   logic                                  rvalid;
   logic [LOG2_CHANNELS-1:0]              rvalid_channel;
   logic [NUM_CHANNELS-1:0]               almostfull;
   logic [NUM_CHANNELS-1:0]               empty;
   logic [NUM_CHANNELS*(LOG2_DEPTH+1)-1:0] count;
`ifdef MULTICHANNEL_FIFOBRAM_ERRCHECK_EN
   logic [NUM_CHANNELS-1:0]               overflow_err;
   logic [NUM_CHANNELS-1:0]               underflow_err;
`endif

   modport master (
      output we, wchannel, wdata, re, rchannel,
      input  rdata, rvalid, rvalid_channel, almostfull, empty, count
`ifdef MULTICHANNEL_FIFOBRAM_ERRCHECK_EN
      , input overflow_err, underflow_err
`endif
   );

   modport slave (
      input  we, wchannel, wdata, re, rchannel,
      output rdata, rvalid, rvalid_channel, almostfull, empty, count
`ifdef MULTICHANNEL_FIFOBRAM_ERRCHECK_EN
      , output overflow_err, underflow_err
`endif
   );

endinterface

// File: rtl/multichannel_fifobram_bram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// Contents are deliberately not reset so it maps onto block RAM.
module simple_dual_port_bram #(
   parameter int WIDTH      = 32,
   parameter int LOG2_DEPTH = 7
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LOG2_DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [LOG2_DEPTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);
   logic [WIDTH-1:0] mem [1 << LOG2_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/multichannel_fifobram.sv
// N-channel FIFO sharing one BRAM; each channel owns a 2**LOG2_DEPTH region addressed {channel, ptr}.
// Define MULTICHANNEL_FIFOBRAM_ERRCHECK_EN to add sticky per-channel overflow/underflow flags.
module multichannel_fifobram
   import multichannel_fifobram_pkg::*;
#(
   parameter int WIDTH             = 32,
   parameter int LOG2_DEPTH        = 5,
   parameter int LOG2_CHANNELS     = 2,
   parameter int ALMOSTFULL_MARGIN = DEFAULT_ALMOSTFULL_MARGIN
) (
   input logic                    clk,
   input logic                    resetn,
   multichannel_fifobram_if.slave bus
);
   localparam int NUM_CHANNELS = 1 << LOG2_CHANNELS;
   localparam int DEPTH        = 1 << LOG2_DEPTH;
   localparam int AW           = LOG2_CHANNELS + LOG2_DEPTH;
   localparam int CW           = LOG2_DEPTH + 1;
   localparam logic [STATUS_COUNT_W-1:0] FULL_LEVEL = STATUS_COUNT_W'(DEPTH);
   localparam logic [STATUS_COUNT_W-1:0] AF_LEVEL   = STATUS_COUNT_W'(DEPTH - ALMOSTFULL_MARGIN);

   logic [LOG2_DEPTH-1:0]      wptr_q [NUM_CHANNELS];
   logic [LOG2_DEPTH-1:0]      rptr_q [NUM_CHANNELS];
   multififo_status_t          status_q [NUM_CHANNELS];
   multififo_status_t          status_d [NUM_CHANNELS];
   logic                       wr_ok;
   logic                       rd_ok;
   logic                       rvalid_q;
   logic [LOG2_CHANNELS-1:0]   rch_q;
   logic [WIDTH-1:0]           bram_rdata;
   logic [NUM_CHANNELS*CW-1:0] count_flat;
   logic [NUM_CHANNELS-1:0]    empty_v;
   logic [NUM_CHANNELS-1:0]    af_v;

   // Acceptance uses pre-update counts, so one address is never read and written in the same cycle
   assign wr_ok = bus.we && (status_q[bus.wchannel].count != FULL_LEVEL);
   assign rd_ok = bus.re && (status_q[bus.rchannel].count != '0);

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         status_d[i] = status_q[i];
         if (wr_ok && bus.wchannel == LOG2_CHANNELS'(i))
            status_d[i].count = status_d[i].count + 1'b1;
         if (rd_ok && bus.rchannel == LOG2_CHANNELS'(i))
            status_d[i].count = status_d[i].count - 1'b1;
         status_d[i].empty      = (status_d[i].count == '0);
         status_d[i].almostfull = (status_d[i].count >= AF_LEVEL);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            wptr_q[i]   <= '0;
            rptr_q[i]   <= '0;
            status_q[i] <= '{empty: 1'b1, almostfull: 1'b0, count: '0};
         end
         rvalid_q <= 1'b0;
         rch_q    <= '0;
      end else begin
         if (wr_ok) wptr_q[bus.wchannel] <= wptr_q[bus.wchannel] + 1'b1;
         if (rd_ok) begin
            rptr_q[bus.rchannel] <= rptr_q[bus.rchannel] + 1'b1;
            rch_q                <= bus.rchannel;
         end
         rvalid_q <= rd_ok;
         for (int i = 0; i < NUM_CHANNELS; i++) status_q[i] <= status_d[i];
      end
   end

   simple_dual_port_bram #(.WIDTH(WIDTH), .LOG2_DEPTH(AW)) u_bram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr ({bus.wchannel, wptr_q[bus.wchannel]}),
      .wdata (bus.wdata),
      .re    (rd_ok),
      .raddr ({bus.rchannel, rptr_q[bus.rchannel]}),
      .rdata (bram_rdata)
   );

   always_comb begin
      count_flat = '0;
      empty_v    = '0;
      af_v       = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         count_flat[count_lsb(i, LOG2_DEPTH) +: CW] = status_q[i].count[CW-1:0];
         empty_v[i] = status_q[i].empty;
         af_v[i]    = status_q[i].almostfull;
      end
   end

   assign bus.count          = count_flat;
   assign bus.empty          = empty_v;
   assign bus.almostfull     = af_v;
   assign bus.rvalid         = rvalid_q;
   assign bus.rvalid_channel = rch_q;
   // BRAM output register is not reset; gating keeps rdata at zero outside valid cycles
   assign bus.rdata          = rvalid_q ? bram_rdata : '0;

`ifdef MULTICHANNEL_FIFOBRAM_ERRCHECK_EN
   logic [NUM_CHANNELS-1:0] ovf_q;
   logic [NUM_CHANNELS-1:0] unf_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         if (bus.we && !wr_ok) ovf_q[bus.wchannel] <= 1'b1;
         if (bus.re && !rd_ok) unf_q[bus.rchannel] <= 1'b1;
      end
   end

   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;
`endif

endmodule

// File: tb/tb_multichannel_fifobram.sv
// Self-checking bench for multichannel_fifobram: vector table, directed corner sequences,
// and randomized traffic against a per-channel queue model.
module tb_multichannel_fifobram;
   import multichannel_fifobram_pkg::*;

   localparam int WIDTH         = 32;
   localparam int LOG2_DEPTH    = 5;
   localparam int LOG2_CHANNELS = 2;
   localparam int NCH           = 1 << LOG2_CHANNELS;
   localparam int DEPTH         = 1 << LOG2_DEPTH;
   localparam int CW            = LOG2_DEPTH + 1;
   localparam int AF_LEVEL      = DEPTH - DEFAULT_ALMOSTFULL_MARGIN;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   multichannel_fifobram_if #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .LOG2_CHANNELS(LOG2_CHANNELS)) bus ();

   multichannel_fifobram #(
      .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .LOG2_CHANNELS(LOG2_CHANNELS),
      .ALMOSTFULL_MARGIN(DEFAULT_ALMOSTFULL_MARGIN)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] q [NCH][$];
   logic [NCH-1:0]   ovf = '0;
   logic [NCH-1:0]   unf = '0;

   typedef struct packed {
      bit          we;
      int          wc;
      logic [31:0] wd;
      bit          re;
      int          rc;
      bit          ev;
      logic [31:0] ed;
      int          ech;
      logic [23:0] ecount;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string tag);
      logic [NCH*CW-1:0] c;
      logic [NCH-1:0]    e;
      logic [NCH-1:0]    a;
      for (int i = 0; i < NCH; i++) begin
         c[i*CW +: CW] = CW'(q[i].size());
         e[i] = (q[i].size() == 0);
         a[i] = (q[i].size() >= AF_LEVEL);
      end
      check({tag, ".count"}, bus.count, c);
      check({tag, ".empty"}, bus.empty, e);
      check({tag, ".almostfull"}, bus.almostfull, a);
`ifdef MULTICHANNEL_FIFOBRAM_ERRCHECK_EN
      check({tag, ".overflow_err"}, bus.overflow_err, ovf);
      check({tag, ".underflow_err"}, bus.underflow_err, unf);
`endif
   endtask

   // One clock of traffic; the model decides acceptance from occupancy before the edge.
   task automatic cycle(input bit w, input int wc, input logic [WIDTH-1:0] wd, input bit r, input int rc);
      bit               wa, ra;
      logic [WIDTH-1:0] ed;
      bus.we       = w;
      bus.wchannel = LOG2_CHANNELS'(wc);
      bus.wdata    = wd;
      bus.re       = r;
      bus.rchannel = LOG2_CHANNELS'(rc);
      wa = w && (q[wc].size() < DEPTH);
      ra = r && (q[rc].size() > 0);
      ed = '0;
      if (ra) ed = q[rc].pop_front();
      if (wa) q[wc].push_back(wd);
      if (w && !wa) ovf[wc] = 1'b1;
      if (r && !ra) unf[rc] = 1'b1;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      bus.re = 1'b0;
      check("rvalid", bus.rvalid, ra);
      if (ra) begin
         check("rdata", bus.rdata, ed);
         check("rvalid_channel", bus.rvalid_channel, rc);
      end
      check_status("st");
   endtask

   task automatic do_reset();
      bus.we = 1'b0;
      bus.re = 1'b0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < NCH; i++) q[i].delete();
      ovf = '0;
      unf = '0;
      @(posedge clk);
      #1;
      check("rst.rvalid", bus.rvalid, 0);
      check("rst.rdata", bus.rdata, 0);
      check("rst.rvalid_channel", bus.rvalid_channel, 0);
      check("rst.empty_all", bus.empty, 4'b1111);
      check_status("rst");
   endtask

   initial begin
      bus.we = 1'b0; bus.wchannel = '0; bus.wdata = '0;
      bus.re = 1'b0; bus.rchannel = '0;

      //           we wc wd         re rc ev ed         ech ecount
      tbl[0]  = '{1'b1, 1, 32'hA0, 1'b0, 0, 1'b0, 32'h0,  0, 24'h000040};
      tbl[1]  = '{1'b1, 1, 32'hA1, 1'b0, 0, 1'b0, 32'h0,  0, 24'h000080};
      tbl[2]  = '{1'b1, 1, 32'hA2, 1'b0, 0, 1'b0, 32'h0,  0, 24'h0000C0};
      tbl[3]  = '{1'b1, 1, 32'hA3, 1'b0, 0, 1'b0, 32'h0,  0, 24'h000100};
      tbl[4]  = '{1'b0, 0, 32'h0,  1'b1, 1, 1'b1, 32'hA0, 1, 24'h0000C0};
      tbl[5]  = '{1'b0, 0, 32'h0,  1'b1, 1, 1'b1, 32'hA1, 1, 24'h000080};
      tbl[6]  = '{1'b0, 0, 32'h0,  1'b1, 1, 1'b1, 32'hA2, 1, 24'h000040};
      tbl[7]  = '{1'b0, 0, 32'h0,  1'b1, 1, 1'b1, 32'hA3, 1, 24'h000000};
      tbl[8]  = '{1'b0, 0, 32'h0,  1'b1, 1, 1'b0, 32'h0,  0, 24'h000000};
      tbl[9]  = '{1'b1, 3, 32'hB0, 1'b1, 1, 1'b0, 32'h0,  0, 24'h040000};
      tbl[10] = '{1'b1, 1, 32'hC0, 1'b1, 1, 1'b0, 32'h0,  0, 24'h040040};
      tbl[11] = '{1'b1, 1, 32'hC1, 1'b1, 3, 1'b1, 32'hB0, 3, 24'h000080};

      do_reset();

      for (int k = 0; k < 12; k++) begin
         cycle(tbl[k].we, tbl[k].wc, tbl[k].wd, tbl[k].re, tbl[k].rc);
         check("tbl.rvalid", bus.rvalid, tbl[k].ev);
         if (tbl[k].ev) begin
            check("tbl.rdata", bus.rdata, tbl[k].ed);
            check("tbl.rvalid_channel", bus.rvalid_channel, tbl[k].ech);
         end
         check("tbl.count", bus.count, tbl[k].ecount);
      end

      // Fill ch2 to full, overflow it, drain it.
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         cycle(1'b1, 2, $urandom(), 1'b0, 0);
         check("fill.af2", bus.almostfull[2], 64'((k + 1) >= AF_LEVEL));
      end
      cycle(1'b1, 2, 32'hDEAD_BEEF, 1'b0, 0);
      check("full.count2", bus.count[2*CW +: CW], DEPTH);
      for (int k = 0; k < DEPTH; k++) cycle(1'b0, 0, '0, 1'b1, 2);
      check("drain.empty2", bus.empty[2], 1);

      // Full channel with simultaneous same-channel pop: write still dropped.
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1, $urandom(), 1'b0, 0);
      cycle(1'b1, 1, 32'h1234_5678, 1'b1, 1);
      check("fullpop.count1", bus.count[1*CW +: CW], DEPTH - 1);

      // Same-cycle write+pop on ch0 with 5 queued, then cross-channel.
      do_reset();
      for (int k = 0; k < 5; k++) cycle(1'b1, 0, $urandom(), 1'b0, 0);
      cycle(1'b1, 0, 32'h5555_0000, 1'b1, 0);
      check("same.count0", bus.count[0 +: CW], 5);
      cycle(1'b1, 3, 32'h3333_0000, 1'b1, 0);
      check("cross.count0", bus.count[0 +: CW], 4);
      check("cross.count3", bus.count[3*CW +: CW], 1);

      // Pointer wrap on ch0 with occupancy hovering near 3.
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, 0, $urandom(), 1'b0, 0);
      for (int k = 0; k < 100; k++) begin
         bit w, r;
         w = (q[0].size() < 3) ? 1'b1 : 1'($urandom_range(0, 1));
         r = (q[0].size() > 3) ? 1'b1 : 1'($urandom_range(0, 1));
         cycle(w, 0, $urandom(), r, 0);
      end

      // Random traffic across all channels.
      for (int k = 0; k < 400; k++)
         cycle(int'($urandom_range(0, 9)) < 6, int'($urandom_range(0, NCH - 1)), $urandom(),
               int'($urandom_range(0, 9)) < 5, int'($urandom_range(0, NCH - 1)));

      // Reset asserted while a pop result is on the output.
      cycle(1'b1, 0, 32'h0000_0055, 1'b0, 0);
      cycle(1'b1, 0, 32'h0000_0066, 1'b1, 0);
      resetn = 1'b0;
      #1;
      check("midrst.rvalid", bus.rvalid, 0);
      check("midrst.empty", bus.empty, 4'b1111);
      check("midrst.count", bus.count, 0);
      check("midrst.rdata", bus.rdata, 0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < NCH; i++) q[i].delete();
      ovf = '0;
      unf = '0;
      @(posedge clk);
      #1;
      check_status("postrst");
      cycle(1'b1, 0, 32'h0000_0077, 1'b0, 0);
      cycle(1'b0, 0, '0, 1'b1, 0);
      check("postrst.rdata", bus.rdata, 32'h0000_0077);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
